video_timing_gen: RTL and testbench
===================================

# video_timing_gen

Parametrised video timing generator that supersedes the active-area-only position counter. It adds full horizontal/vertical blanking (front porch, sync, back porch), programmable sync polarity, a data-enable flag and frame/line event pulses. It sits between the pixel clock domain control and the display output stage. Its position outputs drive the frame-buffer read address and the pattern/sprite logic.

## Interface
Parameters:
- pHActive, 640, active pixels per line
- pHFront, 16, horizontal front porch (pixels)
- pHSync, 96, horizontal sync width (pixels)
- pHBack, 48, horizontal back porch (pixels)
- pVActive, 480, active lines per frame
- pVFront, 10, vertical front porch (lines)
- pVSync, 2, vertical sync width (lines)
- pVBack, 33, vertical back porch (lines)
- pHPol, 0, HSync active level (0 = active-low)
- pVPol, 0, VSync active level (0 = active-low)
- pBitWidth, 11, horizontal counter / oDwp width; must hold HTotal-1
- pBitHeight, 11, vertical counter / oDhp width; must hold VTotal-1

Ports:
- iCLK  in  1  clock
- iRST  in  1  reset. Synchronous, active-high.
- iCKE  in  1  pixel step enable; one pixel per iCLK with iCKE=1
- oHSync  out  1  horizontal sync, polarity per pHPol
- oVSync  out  1  vertical sync, polarity per pVPol
- oDe  out  1  active-video flag
- oDwp  out  pBitWidth  active X position; 0 outside active area
- oDhp  out  pBitHeight  active Y position; 0 outside active area
- oFs  out  1  frame start pulse, at pixel (0,0)
- oLe  out  1  line end pulse, at the last active pixel of each active line
- oFe  out  1  frame end pulse, at pixel (HActive-1, VActive-1)

## Operation
- HTotal = pHActive+pHFront+pHSync+pHBack. VTotal is defined the same way from the vertical parameters. Defaults give 800 x 525.
- Internal rHCnt counts 0..HTotal-1. Each line is ordered: active, front porch, sync, back porch.
- Internal rVCnt counts 0..VTotal-1 in lines, using the same ordering.
- rHCnt advances only when iCKE=1. At HTotal-1 it wraps to 0, not at 2^pBitWidth.
- rVCnt advances only when iCKE=1 and rHCnt==HTotal-1. At VTotal-1 it wraps to 0.
- Decode of the current (rHCnt, rVCnt):
  - hAct = rHCnt < pHActive; vAct = rVCnt < pVActive; De = hAct & vAct.
  - HSync asserted for rHCnt in [pHActive+pHFront, pHActive+pHFront+pHSync-1].
  - VSync asserted for rVCnt in [pVActive+pVFront, pVActive+pVFront+pVSync-1]. It changes only at line boundaries.
  - oDwp = De ? rHCnt : 0; oDhp = De ? rVCnt : 0.
  - Fs = (0,0); Le = De & rHCnt==pHActive-1; Fe = Le & rVCnt==pVActive-1.
- Output registers are split into two groups:
  - Level outputs (oHSync, oVSync, oDe, oDwp, oDhp) load the decode only on iCLK edges with iCKE=1, and hold otherwise.
  - Pulse outputs (oFs, oLe, oFe) load the decode & iCKE on every iCLK edge, so each pulse lasts exactly one iCLK.
- Reset state: counters 0.
- Output reset values: oHSync=~pHPol, oVSync=~pVPol, oDe=0, oDwp=0, oDhp=0, oFs=0, oLe=0, oFe=0.

## Timing
- Latency: outputs show the decode of the counter state held before the iCKE edge, i.e. one iCKE step behind the counters.
- First iCKE cycle after reset: the next edge gives oDe=1, oDwp=0, oDhp=0, oFs=1.
- Consecutive pixels appear on consecutive iCKE-qualified edges. There are no bubbles inside a line.
- oLe and oFe fire on the same cycle for the final active pixel.
- oFs and oFe are one-iCLK pulses even when iCKE is held low for several cycles afterwards.
- iRST has priority over iCKE. Reset mid-frame returns to (0,0) on the next edge with all outputs at reset values. There are no partial pulses.
- Simultaneous horizontal and vertical wrap at (HTotal-1, VTotal-1): both counters go to 0 on the same edge.
- Parameter rules: every porch and sync width must be ≥1, and pHActive, pVActive ≥1. Zero values are unsupported and are not checked at run time.

## Test plan
- Reset, default parameters: hold iRST 5 cycles with iCKE=1 -> all outputs at reset values (oHSync=1, oVSync=1); first edge after release gives oDe=1, oFs=1, oDwp=0.
- One line, iCKE=1: oDe high for 640 edges, then oLe at oDwp=639; oHSync low for exactly 96 edges starting 16 edges after oDe falls; next oDe rise 800 edges after the first.
- Full frame, defaults: oFe once every 420000 iCLKs; oVSync low for 2 lines (1600 edges) starting at line 490; oFs exactly 1 per frame.
- Small config (H 4/1/1/1, V 2/1/1/1, pBit 3, pHPol=1, pVPol=1), 3 frames:
  - HTotal=7 and VTotal=5; frame period 35 edges.
  - oHSync high at hcnt 5, oVSync high for line 3.
  - oDwp/oDhp sequence 0..3 / 0..1.
- iCKE at 1/3 duty: level outputs hold between enables; each oLe/oFs/oFe pulse is 1 iCLK wide; a line takes 2400 iCLKs (defaults).
- Assert iRST at (hcnt=300, line=200) for 1 cycle -> next edge outputs at reset values; next iCKE edge restarts with oFs=1 at (0,0).

Source files
------------

// File: rtl/video_timing_gen.sv
// Video timing generator: raster counters with blanking, programmable sync polarity,
// data-enable, active-area position and one-iCLK frame/line event pulses.
`timescale 1ns/1ps

module video_timing_gen #(
    parameter int unsigned pHActive   = 640,
    parameter int unsigned pHFront    = 16,
    parameter int unsigned pHSync     = 96,
    parameter int unsigned pHBack     = 48,
    parameter int unsigned pVActive   = 480,
    parameter int unsigned pVFront    = 10,
    parameter int unsigned pVSync     = 2,
    parameter int unsigned pVBack     = 33,
    parameter bit          pHPol      = 1'b0,
    parameter bit          pVPol      = 1'b0,
    parameter int unsigned pBitWidth  = 11,
    parameter int unsigned pBitHeight = 11
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic                  iCKE,
    output logic                  oHSync,
    output logic                  oVSync,
    output logic                  oDe,
    output logic [pBitWidth-1:0]  oDwp,
    output logic [pBitHeight-1:0] oDhp,
    output logic                  oFs,
    output logic                  oLe,
    output logic                  oFe
);

    localparam int unsigned cHTotal = pHActive + pHFront + pHSync + pHBack;
    localparam int unsigned cVTotal = pVActive + pVFront + pVSync + pVBack;

    localparam logic [pBitWidth-1:0]  cHOne      = pBitWidth'(1);
    localparam logic [pBitWidth-1:0]  cHLast     = pBitWidth'(cHTotal - 1);
    localparam logic [pBitWidth-1:0]  cHActEnd   = pBitWidth'(pHActive);
    localparam logic [pBitWidth-1:0]  cHLastAct  = pBitWidth'(pHActive - 1);
    localparam logic [pBitWidth-1:0]  cHSyncBeg  = pBitWidth'(pHActive + pHFront);
    localparam logic [pBitWidth-1:0]  cHSyncEnd  = pBitWidth'(pHActive + pHFront + pHSync);

    localparam logic [pBitHeight-1:0] cVOne      = pBitHeight'(1);
    localparam logic [pBitHeight-1:0] cVLast     = pBitHeight'(cVTotal - 1);
    localparam logic [pBitHeight-1:0] cVActEnd   = pBitHeight'(pVActive);
    localparam logic [pBitHeight-1:0] cVLastAct  = pBitHeight'(pVActive - 1);
    localparam logic [pBitHeight-1:0] cVSyncBeg  = pBitHeight'(pVActive + pVFront);
    localparam logic [pBitHeight-1:0] cVSyncEnd  = pBitHeight'(pVActive + pVFront + pVSync);

    logic [pBitWidth-1:0]  r_hcnt;
    logic [pBitHeight-1:0] r_vcnt;

    logic                  r_hsync;
    logic                  r_vsync;
    logic                  r_de;
    logic [pBitWidth-1:0]  r_dwp;
    logic [pBitHeight-1:0] r_dhp;
    logic                  r_fs;
    logic                  r_le;
    logic                  r_fe;

    logic                  w_h_last;
    logic                  w_v_last;
    logic                  w_hact;
    logic                  w_vact;
    logic                  w_de;
    logic                  w_hsync_on;
    logic                  w_vsync_on;
    logic                  w_hsync;
    logic                  w_vsync;
    logic [pBitWidth-1:0]  w_dwp;
    logic [pBitHeight-1:0] w_dhp;
    logic                  w_fs;
    logic                  w_le;
    logic                  w_fe;

    assign w_h_last = (r_hcnt == cHLast);
    assign w_v_last = (r_vcnt == cVLast);

    // Raster counters: wrap at the configured totals, not at the counter width.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (iCKE) begin
            if (w_h_last) begin
                r_hcnt <= '0;
                r_vcnt <= w_v_last ? '0 : r_vcnt + cVOne;
            end else begin
                r_hcnt <= r_hcnt + cHOne;
            end
        end
    end

    assign w_hact     = (r_hcnt < cHActEnd);
    assign w_vact     = (r_vcnt < cVActEnd);
    assign w_de       = w_hact & w_vact;
    assign w_hsync_on = (r_hcnt >= cHSyncBeg) && (r_hcnt < cHSyncEnd);
    assign w_vsync_on = (r_vcnt >= cVSyncBeg) && (r_vcnt < cVSyncEnd);
    assign w_hsync    = w_hsync_on ? pHPol : ~pHPol;
    assign w_vsync    = w_vsync_on ? pVPol : ~pVPol;
    assign w_dwp      = w_de ? r_hcnt : '0;
    assign w_dhp      = w_de ? r_vcnt : '0;
    assign w_fs       = (r_hcnt == '0) && (r_vcnt == '0);
    assign w_le       = w_de && (r_hcnt == cHLastAct);
    assign w_fe       = w_le && (r_vcnt == cVLastAct);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_hsync <= ~pHPol;
            r_vsync <= ~pVPol;
            r_de    <= 1'b0;
            r_dwp   <= '0;
            r_dhp   <= '0;
        end else if (iCKE) begin
            r_hsync <= w_hsync;
            r_vsync <= w_vsync;
            r_de    <= w_de;
            r_dwp   <= w_dwp;
            r_dhp   <= w_dhp;
        end
    end

    // Event pulses reload every edge so they clear even while iCKE stays low.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_fs <= 1'b0;
            r_le <= 1'b0;
            r_fe <= 1'b0;
        end else begin
            r_fs <= w_fs & iCKE;
            r_le <= w_le & iCKE;
            r_fe <= w_fe & iCKE;
        end
    end

    assign oHSync = r_hsync;
    assign oVSync = r_vsync;
    assign oDe    = r_de;
    assign oDwp   = r_dwp;
    assign oDhp   = r_dhp;
    assign oFs    = r_fs;
    assign oLe    = r_le;
    assign oFe    = r_fe;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: default 800x525 instance plus a tiny 7x5 instance, driven in
// lockstep; a raster model queues expected outputs per edge, compared one step later.
`timescale 1ns/1ps

module tb_video_timing_gen;

    typedef struct {
        int   ha, hf, hs, hb, va, vf, vs, vb;
        logic hpol, vpol;
    } cfg_t;

    typedef struct {
        logic        hs, vs, de, fs, le, fe;
        logic [31:0] dwp, dhp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cke = 1'b1;

    logic        hs0, vs0, de0, fs0, le0, fe0;
    logic [10:0] dwp0, dhp0;
    logic        hs1, vs1, de1, fs1, le1, fe1;
    logic [2:0]  dwp1, dhp1;

    int checks   = 0;
    int failures = 0;

    cfg_t c0, c1;
    int   h0, v0, h1, v1;
    exp_t l0, l1;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    video_timing_gen dut0 (
        .iCLK(clk), .iRST(rst), .iCKE(cke),
        .oHSync(hs0), .oVSync(vs0), .oDe(de0), .oDwp(dwp0), .oDhp(dhp0),
        .oFs(fs0), .oLe(le0), .oFe(fe0)
    );

    video_timing_gen #(
        .pHActive(4), .pHFront(1), .pHSync(1), .pHBack(1),
        .pVActive(2), .pVFront(1), .pVSync(1), .pVBack(1),
        .pHPol(1'b1), .pVPol(1'b1), .pBitWidth(3), .pBitHeight(3)
    ) dut1 (
        .iCLK(clk), .iRST(rst), .iCKE(cke),
        .oHSync(hs1), .oVSync(vs1), .oDe(de1), .oDwp(dwp1), .oDhp(dhp1),
        .oFs(fs1), .oLe(le1), .oFe(fe1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic exp_t decode(input cfg_t c, input int h, input int v);
        exp_t d;
        logic in_hs, in_vs;
        d.de  = (h < c.ha) && (v < c.va);
        in_hs = (h >= c.ha + c.hf) && (h < c.ha + c.hf + c.hs);
        in_vs = (v >= c.va + c.vf) && (v < c.va + c.vf + c.vs);
        d.hs  = in_hs ? c.hpol : !c.hpol;
        d.vs  = in_vs ? c.vpol : !c.vpol;
        d.dwp = d.de ? h : 0;
        d.dhp = d.de ? v : 0;
        d.fs  = (h == 0) && (v == 0);
        d.le  = d.de && (h == c.ha - 1);
        d.fe  = d.le && (v == c.va - 1);
        return d;
    endfunction

    task automatic model_step(input cfg_t c, inout int h, inout int v, inout exp_t lvl,
                              input logic r, input logic k, output exp_t e);
        exp_t d;
        int   htot, vtot;
        htot = c.ha + c.hf + c.hs + c.hb;
        vtot = c.va + c.vf + c.vs + c.vb;
        if (r) begin
            h = 0;
            v = 0;
            lvl.hs  = !c.hpol;
            lvl.vs  = !c.vpol;
            lvl.de  = 1'b0;
            lvl.dwp = 0;
            lvl.dhp = 0;
            e = lvl;
            e.fs = 1'b0;
            e.le = 1'b0;
            e.fe = 1'b0;
        end else begin
            d = decode(c, h, v);
            if (k) lvl = d;
            e = lvl;
            e.fs = d.fs && k;
            e.le = d.le && k;
            e.fe = d.fe && k;
            if (k) begin
                if (h == htot - 1) begin
                    h = 0;
                    v = (v == vtot - 1) ? 0 : v + 1;
                end else begin
                    h = h + 1;
                end
            end
        end
    endtask

    task automatic cmp(input string tag, input exp_t g, input exp_t e);
        chk({tag, ".oHSync"}, 32'(g.hs), 32'(e.hs));
        chk({tag, ".oVSync"}, 32'(g.vs), 32'(e.vs));
        chk({tag, ".oDe"},    32'(g.de), 32'(e.de));
        chk({tag, ".oDwp"},   g.dwp, e.dwp);
        chk({tag, ".oDhp"},   g.dhp, e.dhp);
        chk({tag, ".oFs"},    32'(g.fs), 32'(e.fs));
        chk({tag, ".oLe"},    32'(g.le), 32'(e.le));
        chk({tag, ".oFe"},    32'(g.fe), 32'(e.fe));
    endtask

    // Drive one cycle, queue the model's prediction, then compare after the edge.
    task automatic step(input logic r, input logic k);
        exp_t e;
        exp_t g;
        rst = r;
        cke = k;
        model_step(c0, h0, v0, l0, r, k, e);
        q0.push_back(e);
        model_step(c1, h1, v1, l1, r, k, e);
        q1.push_back(e);
        @(posedge clk);
        #1;
        g = '{hs: hs0, vs: vs0, de: de0, fs: fs0, le: le0, fe: fe0,
              dwp: 32'(dwp0), dhp: 32'(dhp0)};
        e = q0.pop_front();
        cmp("d0", g, e);
        g = '{hs: hs1, vs: vs1, de: de1, fs: fs1, le: le1, fe: fe1,
              dwp: 32'(dwp1), dhp: 32'(dhp1)};
        e = q1.pop_front();
        cmp("d1", g, e);
    endtask

    initial begin
        int de_cnt, hs_low, hs_first, le_cnt;
        int fs1_cnt, fe1_cnt, fs1_a, fs1_b, hs1_cnt, vs1_cnt, dwp1_max, dhp1_max;

        c0 = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33,
               hpol: 1'b0, vpol: 1'b0};
        c1 = '{ha: 4, hf: 1, hs: 1, hb: 1, va: 2, vf: 1, vs: 1, vb: 1,
               hpol: 1'b1, vpol: 1'b1};

        repeat (5) step(1'b1, 1'b1);
        chk("rst.oHSync", 32'(hs0), 32'd1);
        chk("rst.oVSync", 32'(vs0), 32'd1);
        chk("rst.oDe",    32'(de0), 32'd0);
        chk("rst.small.oHSync", 32'(hs1), 32'd0);

        de_cnt = 0; hs_low = 0; hs_first = -1; le_cnt = 0;
        fs1_cnt = 0; fe1_cnt = 0; fs1_a = -1; fs1_b = -1;
        hs1_cnt = 0; vs1_cnt = 0; dwp1_max = 0; dhp1_max = 0;
        for (int i = 0; i < 1600; i++) begin
            step(1'b0, 1'b1);
            if (i == 0) begin
                chk("first.oDe",  32'(de0),  32'd1);
                chk("first.oFs",  32'(fs0),  32'd1);
                chk("first.oDwp", 32'(dwp0), 32'd0);
                chk("first.oDhp", 32'(dhp0), 32'd0);
            end
            if (i < 800) begin
                if (de0) de_cnt++;
                if (!hs0) begin
                    hs_low++;
                    if (hs_first < 0) hs_first = i;
                end
                if (le0) begin
                    le_cnt++;
                    chk("line.le_at_dwp", 32'(dwp0), 32'd639);
                end
            end
            if (i == 799) chk("line.de_low_before_wrap", 32'(de0), 32'd0);
            if (i == 800) chk("line.de_rise_at_800", 32'(de0), 32'd1);
            if (i < 105) begin
                if (fs1) begin
                    fs1_cnt++;
                    if (fs1_a < 0) fs1_a = i;
                    else if (fs1_b < 0) fs1_b = i;
                end
                if (fe1) fe1_cnt++;
                if (dwp1 > dwp1_max[2:0]) dwp1_max = 32'(dwp1);
                if (dhp1 > dhp1_max[2:0]) dhp1_max = 32'(dhp1);
            end
            if (i < 35) begin
                if (hs1) hs1_cnt++;
                if (vs1) vs1_cnt++;
            end
        end
        chk("line.de_edges",       32'(de_cnt),   32'd640);
        chk("line.hsync_low",      32'(hs_low),   32'd96);
        chk("line.hsync_start",    32'(hs_first), 32'd656);
        chk("line.le_count",       32'(le_cnt),   32'd1);
        chk("small.fs_per_3frm",   32'(fs1_cnt),  32'd3);
        chk("small.fe_per_3frm",   32'(fe1_cnt),  32'd3);
        chk("small.frame_period",  32'(fs1_b - fs1_a), 32'd35);
        chk("small.hsync_edges",   32'(hs1_cnt),  32'd5);
        chk("small.vsync_edges",   32'(vs1_cnt),  32'd7);
        chk("small.dwp_max",       32'(dwp1_max), 32'd3);
        chk("small.dhp_max",       32'(dhp1_max), 32'd1);

        // One-in-three enable: three lines take 7200 iCLKs, each oLe exactly one iCLK wide.
        le_cnt = 0;
        for (int i = 0; i < 7200; i++) begin
            step(1'b0, (i % 3) == 0);
            if (le0) le_cnt++;
        end
        chk("duty.le_cycles", 32'(le_cnt), 32'd3);

        step(1'b1, 1'b1);
        chk("midrst.oDe",    32'(de0), 32'd0);
        chk("midrst.oHSync", 32'(hs0), 32'd1);
        step(1'b0, 1'b0);
        chk("midrst.hold.oFs", 32'(fs0), 32'd0);
        step(1'b0, 1'b1);
        chk("midrst.restart.oFs",  32'(fs0),  32'd1);
        chk("midrst.restart.oDwp", 32'(dwp0), 32'd0);

        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
